qam_frame_sync: RTL

Frame synchronizer and deserializer sitting directly downstream of the 16QAM demapper. Consumes the demapper's serial bit stream on the data clock, hunts for a fixed sync word, and once locked emits payload bytes with a valid strobe. A flywheel tolerates a configurable number of corrupted sync words before dropping lock.

---
 rtl/qam_frame_sync.sv | 86 ++++++++
 1 files changed

// File: rtl/qam_frame_sync.sv
// qam_frame_sync: hunts for a sync word in the demapped bit stream, then deserializes payload bytes with a flywheel on sync loss
module qam_frame_sync #(
  parameter logic [15:0] SYNC_WORD     = 16'h1ACF,
  parameter int          PAYLOAD_BYTES = 32,
  parameter int          MISS_LIMIT    = 3
) (
  input  logic       dclk,
  input  logic       rst,
  input  logic       en,
  input  logic       data_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       sync_miss,
  output logic       locked
);
  typedef enum logic [1:0] {SEARCH, PAYLOAD, CHECK} state_t;
  state_t      r_state, w_state_nxt;
  logic [14:0] r_sr;
  logic [4:0]  r_fill;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_byte_cnt;
  logic [2:0]  r_miss_cnt;
  logic [15:0] w_win;
  logic [2:0]  w_miss_nxt;
  logic        w_sync, w_hit, w_byte_done, w_last_byte, w_chk_end, w_good, w_bad, w_drop;
  logic        w_bv_nxt, w_fs_nxt, w_sm_nxt, w_lk_nxt;
  assign w_win       = {r_sr, data_in};
  assign w_sync      = w_win == SYNC_WORD;
  assign w_miss_nxt  = r_miss_cnt + 3'd1;
  assign w_hit       = en && r_state == SEARCH && r_fill >= 5'd15 && w_sync;
  assign w_byte_done = en && r_state == PAYLOAD && r_bit_cnt[2:0] == 3'd7;
  assign w_last_byte = w_byte_done && r_byte_cnt == 8'(PAYLOAD_BYTES - 1);
  assign w_chk_end   = en && r_state == CHECK && r_bit_cnt == 4'd15;
  assign w_good      = w_chk_end && w_sync;
  assign w_bad       = w_chk_end && !w_sync;
  assign w_drop      = w_bad && w_miss_nxt == 3'(MISS_LIMIT);
  // state register
  always_ff @(posedge dclk)
    r_state <= rst ? SEARCH : w_state_nxt;
  // next state: every transition is qualified by an accepted bit
  always_comb
    w_state_nxt = (w_hit || w_good || (w_bad && !w_drop)) ? PAYLOAD :
                  w_last_byte ? CHECK :
                  w_drop ? SEARCH : r_state;
  // next output values, registered below
  always_comb begin
    w_bv_nxt = w_byte_done;
    w_fs_nxt = w_hit || w_good;
    w_sm_nxt = w_bad;
    w_lk_nxt = w_state_nxt != SEARCH;
  end
  // shift register, fill, bit/byte/miss counters advance only on accepted bits
  always_ff @(posedge dclk) begin
    if (rst) begin
      r_sr       <= '0;
      r_fill     <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_miss_cnt <= '0;
    end else if (en) begin
      r_sr       <= w_win[14:0];
      r_fill     <= w_drop ? 5'd0 : r_fill == 5'd16 ? r_fill : r_fill + 5'd1;
      r_bit_cnt  <= (w_hit || w_last_byte || w_chk_end) ? 4'd0 :
                    r_state == PAYLOAD ? {1'b0, r_bit_cnt[2:0] + 3'd1} : r_bit_cnt + 4'd1;
      r_byte_cnt <= (w_hit || w_chk_end) ? 8'd0 : w_byte_done ? r_byte_cnt + 8'd1 : r_byte_cnt;
      r_miss_cnt <= (w_hit || w_good || w_drop) ? 3'd0 : w_bad ? w_miss_nxt : r_miss_cnt;
    end
  end
  // registered outputs; strobes fall on idle cycles, byte_out holds between strobes
  always_ff @(posedge dclk) begin
    if (rst) begin
      byte_out    <= 8'h00;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      sync_miss   <= 1'b0;
      locked      <= 1'b0;
    end else begin
      byte_out    <= w_byte_done ? w_win[7:0] : byte_out;
      byte_valid  <= w_bv_nxt;
      frame_start <= w_fs_nxt;
      sync_miss   <= w_sm_nxt;
      locked      <= w_lk_nxt;
    end
  end
endmodule
